// File: rtl/gray_binarize_bbox_if.sv
// gray_binarize_bbox_if
// Pixel video stream bundle carried between image-processing stages.
//   vsync : frame valid, high for the whole active frame
//   hsync : line valid, high for the active part of a line
//   clken : pixel valid
//   img_y : 8-bit gray pixel
// The master modport drives the stream and the slave modport consumes it.
interface gray_binarize_bbox_if;
    logic       vsync;
    logic       hsync;
    logic       clken;
    logic [7:0] img_y;

    modport master (output vsync, hsync, clken, img_y);
    modport slave  (input  vsync, hsync, clken, img_y);
endinterface

// File: rtl/gray_binarize_bbox.sv
// gray_binarize_bbox
// Thresholds a median-filtered gray stream into a 0x00/0xFF foreground mask,
// and accumulates the per-frame bounding box and foreground pixel count of the
// hand region. The box is published once per frame, one cycle after vsync is
// first sampled low.
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   thresh            binarization threshold (foreground when pixel > thresh)
//   pre               input stream (slave)
//   post              mask stream, 1-cycle latency (master)
//   box_valid         one-cycle pulse when the box outputs are updated
//   box_found         last frame had at least MIN_PIXELS foreground pixels
//   box_xmin/xmax     inclusive column bounds (0 when not found)
//   box_ymin/ymax     inclusive row bounds (0 when not found)
//   box_count         foreground pixels in the last frame
// Optional feature macro BBOX_CENTER_EN: adds box_xc/box_yc, the box centre.
module gray_binarize_bbox #(
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter int CNT_W      = 19,
    parameter int MIN_PIXELS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         thresh,
    gray_binarize_bbox_if.slave  pre,
    gray_binarize_bbox_if.master post,
    output logic               box_valid,
    output logic               box_found,
    output logic [X_W-1:0]     box_xmin,
    output logic [X_W-1:0]     box_xmax,
    output logic [Y_W-1:0]     box_ymin,
    output logic [Y_W-1:0]     box_ymax,
`ifdef BBOX_CENTER_EN
    output logic [X_W-1:0]     box_xc,
    output logic [Y_W-1:0]     box_yc,
`endif
    output logic [CNT_W-1:0]   box_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t             state_q;
    logic               armed_q;

    // Registered copies of the stream; they double as the edge detectors.
    logic               vsync_q, hsync_q, clken_q;
    logic [7:0]         post_y_q;

    logic [X_W-1:0]     x_q, x_d, x_base;
    logic [Y_W-1:0]     y_q, y_d, y_base;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [X_W-1:0]     xmin_q, xmin_d, xmax_q, xmax_d;
    logic [Y_W-1:0]     ymin_q, ymin_d, ymax_q, ymax_d;

    logic               accept, fg, frame_start, frame_end, line_end, start_accum;

    logic               box_valid_q, box_found_q;
    logic [X_W-1:0]     box_xmin_q, box_xmax_q;
    logic [Y_W-1:0]     box_ymin_q, box_ymax_q;
    logic [CNT_W-1:0]   box_count_q;
    logic               found_now;
`ifdef BBOX_CENTER_EN
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic [X_W-1:0]     box_xc_q;
    logic [Y_W-1:0]     box_yc_q;
`endif

    always_comb begin
        accept      = pre.vsync & pre.hsync & pre.clken;
        fg          = pre.img_y > thresh;
        frame_start = pre.vsync & ~vsync_q;
        frame_end   = ~pre.vsync & vsync_q;
        line_end    = ~pre.hsync & hsync_q;
        // A frame start seen before any vsync-low gap (e.g. straight after a
        // mid-frame reset) is a partial frame and must not be accumulated.
        start_accum = frame_start & armed_q;

        // Coordinates of the pixel in this cycle: the counters as they stand
        // after any clear implied by this cycle's edges.
        x_base = (frame_start | line_end) ? '0 : x_q;
        y_base = frame_start ? '0 : y_q;

        x_d = x_base;
        if (accept && (x_base != '1))
            x_d = x_base + 1'b1;

        // x_q != 0 means the line that just ended had at least one pixel.
        y_d = y_base;
        if (!frame_start && line_end && (x_q != '0) && (y_q != '1))
            y_d = y_q + 1'b1;

        if (start_accum) begin
            count_d = '0;
            xmin_d  = '1;
            xmax_d  = '0;
            ymin_d  = '1;
            ymax_d  = '0;
        end else begin
            count_d = count_q;
            xmin_d  = xmin_q;
            xmax_d  = xmax_q;
            ymin_d  = ymin_q;
            ymax_d  = ymax_q;
        end

        if ((start_accum || state_q == ACCUM) && accept && fg) begin
            if (count_d != '1) count_d = count_d + 1'b1;
            if (x_base < xmin_d) xmin_d = x_base;
            if (x_base > xmax_d) xmax_d = x_base;
            if (y_base < ymin_d) ymin_d = y_base;
            if (y_base > ymax_d) ymax_d = y_base;
        end

        found_now = count_q >= CNT_W'(MIN_PIXELS);
`ifdef BBOX_CENTER_EN
        sum_x = {1'b0, xmin_q} + {1'b0, xmax_q};
        sum_y = {1'b0, ymin_q} + {1'b0, ymax_q};
`endif
    end

    // Pixel path and datapath counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            hsync_q  <= 1'b0;
            clken_q  <= 1'b0;
            post_y_q <= 8'h00;
            x_q      <= '0;
            y_q      <= '0;
            count_q  <= '0;
            xmin_q   <= '1;
            xmax_q   <= '0;
            ymin_q   <= '1;
            ymax_q   <= '0;
        end else begin
            vsync_q  <= pre.vsync;
            hsync_q  <= pre.hsync;
            clken_q  <= pre.clken;
            post_y_q <= (accept && fg) ? 8'hFF : 8'h00;
            x_q      <= x_d;
            y_q      <= y_d;
            count_q  <= count_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
        end
    end

    // Frame FSM with registered box outputs. The box is latched on the edge
    // that first samples vsync low, so box_valid is high during REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            box_valid_q <= 1'b0;
            box_found_q <= 1'b0;
            box_count_q <= '0;
            box_xmin_q  <= '0;
            box_xmax_q  <= '0;
            box_ymin_q  <= '0;
            box_ymax_q  <= '0;
`ifdef BBOX_CENTER_EN
            box_xc_q    <= '0;
            box_yc_q    <= '0;
`endif
        end else begin
            box_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!pre.vsync) armed_q <= 1'b1;
                    if (start_accum) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (frame_end) begin
                        state_q     <= REPORT;
                        box_valid_q <= 1'b1;
                        box_found_q <= found_now;
                        box_count_q <= count_q;
                        box_xmin_q  <= found_now ? xmin_q : '0;
                        box_xmax_q  <= found_now ? xmax_q : '0;
                        box_ymin_q  <= found_now ? ymin_q : '0;
                        box_ymax_q  <= found_now ? ymax_q : '0;
`ifdef BBOX_CENTER_EN
                        box_xc_q    <= found_now ? sum_x[X_W:1] : '0;
                        box_yc_q    <= found_now ? sum_y[Y_W:1] : '0;
`endif
                    end
                end
                REPORT: state_q <= start_accum ? ACCUM : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign post.vsync = vsync_q;
    assign post.hsync = hsync_q;
    assign post.clken = clken_q;
    assign post.img_y = post_y_q;

    assign box_valid = box_valid_q;
    assign box_found = box_found_q;
    assign box_count = box_count_q;
    assign box_xmin  = box_xmin_q;
    assign box_xmax  = box_xmax_q;
    assign box_ymin  = box_ymin_q;
    assign box_ymax  = box_ymax_q;
`ifdef BBOX_CENTER_EN
    assign box_xc    = box_xc_q;
    assign box_yc    = box_yc_q;
`endif

endmodule

// File: doc/gray_binarize_bbox.md
Name: gray_binarize_bbox

Overview:
- Stage directly downstream of the 3x3 median gray filter; consumes its post_frame_* stream and filtered gray pixel.
- Thresholds each pixel to a 1-bit foreground mask, forwarded as an 8-bit 0x00/0xFF stream.
- Accumulates the per-frame bounding box and foreground pixel count of the hand region.
- Publishes the box once per frame for the gesture classifier.

Parameters:
- X_W, 11, width of column counter and x coordinates.
- Y_W, 10, width of row counter and y coordinates.
- CNT_W, 19, width of foreground pixel counter.
- MIN_PIXELS, 256, minimum foreground count for a frame to report box_found=1.

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  synchronous active-high reset.
- thresh  in  8  binarization threshold; sampled every cycle.
- pre_frame_vsync  in  1  frame valid, high for whole active frame.
- pre_frame_hsync  in  1  line valid, high for active line.
- pre_frame_clken  in  1  pixel valid.
- pre_img_Y  in  8  median-filtered gray pixel.
- post_frame_vsync  out  1  vsync delayed 1 cycle.
- post_frame_hsync  out  1  hsync delayed 1 cycle.
- post_frame_clken  out  1  clken delayed 1 cycle.
- post_img_Y  out  8  0xFF if foreground else 0x00.
- box_valid  out  1  one-cycle pulse: box outputs updated.
- box_found  out  1  last completed frame had count >= MIN_PIXELS.
- box_xmin/box_xmax  out  X_W  column bounds, inclusive.
- box_ymin/box_ymax  out  Y_W  row bounds, inclusive.
- box_count  out  CNT_W  foreground pixels in last frame.

Behaviour:
- Reset: all outputs 0. Internal state: armed=0, x=0, y=0, count=0, xmin/ymin=all-ones, xmax/ymax=0.
- Pixel path:
  - fg = (pre_img_Y > thresh), computed when a pixel is accepted.
  - Pixel accepted when vsync && hsync && clken in the same cycle.
  - All post_* outputs registered; latency exactly 1 cycle.
  - post_img_Y = 0x00 on any cycle where the delayed clken is 0.
- Edge detection:
  - vsync_d and hsync_d are registered copies of the inputs.
  - Frame start = vsync && !vsync_d. Frame end = !vsync && vsync_d. Line end = !hsync && hsync_d.
- Counters:
  - x increments per accepted pixel and saturates at all-ones; cleared at line end.
  - y increments at line end only if the line contained at least 1 accepted pixel; saturates.
  - x and y both cleared at frame start.
- Accumulation (only while armed=1):
  - On an accepted fg pixel, update xmin=min(xmin,x), xmax=max(xmax,x), ymin=min(ymin,y), ymax=max(ymax,y).
  - count increments on each accepted fg pixel and saturates at all-ones.
- FSM states: IDLE (armed=0), ACCUM, REPORT.
  - IDLE -> ACCUM on frame start, clearing the accumulators.
  - ACCUM -> REPORT on frame end. Pixels accepted in the last vsync-high cycle are included.
  - REPORT lasts 1 cycle, then -> IDLE with armed kept at 1.
  - Next frame start -> ACCUM.
- REPORT cycle (the cycle after vsync is first sampled low):
  - box_valid=1.
  - box_count <= count.
  - box_found <= (count >= MIN_PIXELS).
  - If found, load the box registers; otherwise the box registers are set to 0.
  - Outputs hold until the next REPORT.
- Simultaneous frame end and line end: the line-end y increment is irrelevant; the frame reports normally.
- Reset mid-frame: state returns to IDLE with armed=0. The partial frame is discarded, with no box_valid until a full frame (frame start..frame end) has been observed.
- Frame start without a preceding frame end (glitch): accumulators restart and no report is issued.
- Zero-pixel frame: box_valid still pulses, with box_found=0 and box_count=0.

Optional Feature:
- Macro BBOX_CENTER_EN.
- Defined:
  - Adds outputs box_xc (X_W) = (xmin+xmax)>>1 and box_yc (Y_W) = (ymin+ymax)>>1.
  - Both are computed with a one-bit-wider sum and registered in the REPORT cycle alongside the box.
  - Both are 0 on reset and 0 when box_found=0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a 4x3 frame of all-0x10 pixels with thresh=0x80 -> post_img_Y all 0x00 at 1-cycle latency; box_valid pulse with box_found=0 and box_count=0.
- 640x480 frame, thresh=0x80, pixels 0xC0 in columns 100..199 and rows 50..149, MIN_PIXELS=256 -> box_found=1, x 100..199, y 50..149, count=10000 (centre 149,99 with BBOX_CENTER_EN).
- Same frame with a 10x10 fg patch only -> count=100 < 256, box_found=0, box coordinates 0.
- Last accepted pixel (639,479) is fg, in the final cycle before vsync falls -> included: xmax=639, ymax=479; box_valid exactly 1 cycle after vsync is first sampled low.
- Assert rst for 1 cycle mid-frame, then let the frame finish -> no box_valid for that frame; the next full frame reports correctly.
- Pixel equal to thresh (0x80 with thresh=0x80) -> background; 0x81 -> foreground.
